// File: rtl/hsci_axim_pkg.sv
// hsci_axim_pkg: shared types and constants for the HSCI AXI4-Lite command master.
package hsci_axim_pkg;
   typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
   localparam logic [1:0] RESP_TIMEOUT = 2'b11;
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
   typedef struct packed {
      logic write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;
endpackage

// File: rtl/axi4_lite.sv
// axi4_lite: AXI4-Lite channel bundle with master and slave views.
interface axi4_lite #(parameter int ADDR_WIDTH = 18);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0] awprot;
   logic awvalid, awready;
   logic [31:0] wdata;
   logic [3:0] wstrb;
   logic wvalid, wready;
   logic [1:0] bresp;
   logic bvalid, bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0] arprot;
   logic arvalid, arready;
   logic [31:0] rdata;
   logic [1:0] rresp;
   logic rvalid, rready;
   modport master(output awaddr, awprot, awvalid, input awready, output wdata, wstrb, wvalid,
                  input wready, input bresp, bvalid, output bready, output araddr, arprot, arvalid,
                  input arready, input rdata, rresp, rvalid, output rready);
   modport slave(input awaddr, awprot, awvalid, output awready, input wdata, wstrb, wvalid,
                 output wready, output bresp, bvalid, input bready, input araddr, arprot, arvalid,
                 output arready, output rdata, rresp, rvalid, input rready);
endinterface

// File: rtl/hsci_axi_lite_master.sv
// hsci_axi_lite_master: single-outstanding command/response to AXI4-Lite initiator.
// Optional watchdog on AXI waits enabled by defining HSCI_AXIM_TIMEOUT_EN.
module hsci_axi_lite_master
   import hsci_axim_pkg::*;
#(
   parameter int ADDR_WIDTH = 18,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  axi_clk,
   input  logic                  axi_reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  busy,
   axi4_lite.master              axi
);
   state_t r_state, w_next;
   cmd_t r_cmd;
   logic r_aw_done, r_w_done;
   logic [31:0] r_rdata;
   logic [1:0] r_resp;
   logic w_aw_hs, w_w_hs, w_wr_done, w_expire, w_unused;

   assign w_aw_hs = axi.awvalid & axi.awready;
   assign w_w_hs = axi.wvalid & axi.wready;
   assign w_wr_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

   assign cmd_ready = r_state == IDLE;
   assign busy = r_state != IDLE;
   assign rsp_valid = r_state == RSP;
   assign rsp_rdata = r_rdata;
   assign rsp_resp = r_resp;

   // Valids come only from state and done flags, never from a ready input.
   assign axi.awaddr = ADDR_WIDTH'(r_cmd.addr);
   assign axi.araddr = ADDR_WIDTH'(r_cmd.addr);
   assign axi.awprot = 3'b000;
   assign axi.arprot = 3'b000;
   assign axi.wdata = r_cmd.wdata;
   assign axi.wstrb = 4'hF;
   assign axi.awvalid = (r_state == WR_ADDR_DATA) & ~r_aw_done;
   assign axi.wvalid = (r_state == WR_ADDR_DATA) & ~r_w_done;
   assign axi.bready = r_state == WR_RESP;
   assign axi.arvalid = r_state == RD_ADDR;
   assign axi.rready = r_state == RD_DATA;

`ifdef HSCI_AXIM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] r_cnt;
   always_ff @(posedge axi_clk)
      r_cnt <= (axi_reset || w_next != r_state) ? '0 : r_cnt + 1'b1;
   assign w_expire = r_cnt == CW'(TIMEOUT_CYCLES - 1);
   assign w_unused = ^{r_cmd.write, r_cmd.addr};
`else
   assign w_expire = 1'b0;
   assign w_unused = ^{r_cmd.write, r_cmd.addr} ^ (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge axi_clk)
      r_state <= axi_reset ? IDLE : w_next;

   // A handshake always takes priority over watchdog expiry.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:         w_next = cmd_valid ? (cmd_write ? WR_ADDR_DATA : RD_ADDR) : IDLE;
         WR_ADDR_DATA: w_next = w_wr_done ? WR_RESP : (w_expire ? RSP : WR_ADDR_DATA);
         WR_RESP:      w_next = (axi.bvalid | w_expire) ? RSP : WR_RESP;
         RD_ADDR:      w_next = axi.arready ? RD_DATA : (w_expire ? RSP : RD_ADDR);
         RD_DATA:      w_next = (axi.rvalid | w_expire) ? RSP : RD_DATA;
         RSP:          w_next = rsp_ready ? IDLE : RSP;
         default:      w_next = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         r_cmd <= '0;
         r_aw_done <= 1'b0;
         r_w_done <= 1'b0;
         r_rdata <= '0;
         r_resp <= '0;
      end else begin
         if (cmd_ready && cmd_valid)
            r_cmd <= '{write: cmd_write, addr: 32'(cmd_addr) & ~32'h3, wdata: cmd_wdata};
         r_aw_done <= (r_state == WR_ADDR_DATA) & (r_aw_done | w_aw_hs);
         r_w_done <= (r_state == WR_ADDR_DATA) & (r_w_done | w_w_hs);
         if (r_state == WR_RESP && axi.bvalid) begin
            r_resp <= axi.bresp;
            r_rdata <= '0;
         end else if (r_state == RD_DATA && axi.rvalid) begin
            r_resp <= axi.rresp;
            r_rdata <= axi.rdata;
         end else if (r_state != RSP && w_next == RSP) begin
            r_resp <= RESP_TIMEOUT;
            r_rdata <= TIMEOUT_RDATA;
         end
      end
   end
endmodule

// File: tb/tb_hsci_axi_lite_master.sv
// tb_hsci_axi_lite_master: directed and randomized checks of the AXI4-Lite master
// against a behavioural memory slave and a flat reference memory.
module tb_hsci_axi_lite_master;
   localparam int AW = 18;
`ifdef HSCI_AXIM_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 256;
`endif
   logic axi_clk = 1'b0;
   logic axi_reset, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, busy;
   logic [AW-1:0] cmd_addr;
   logic [31:0] cmd_wdata, rsp_rdata;
   logic [1:0] rsp_resp;
   int errors = 0, checks = 0;

   always #5 axi_clk = ~axi_clk;

   axi4_lite #(.ADDR_WIDTH(AW)) axi();

   hsci_axi_lite_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .axi_clk(axi_clk), .axi_reset(axi_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .axi(axi));

   // slave configuration and observation, shared with the main sequence
   bit rnd_mode = 0, aw_first = 0, b_block = 0;
   int rd_lat = 0, rready_cnt = 0, bready_cnt = 0, w_stall_cnt = 0;
   logic [AW-1:0] last_awaddr = '0;
   logic [31:0] last_wdata = '0;
   logic [3:0] last_wstrb = '0;
   logic [AW-1:0] awq[$];
   logic [31:0] wq[$];
   logic [1:0] bq[$];
   logic [31:0] smem[256];
   logic [31:0] ref_mem[256];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit coin();
      return rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
   endfunction

   // memory slave: decides readies/valids at each falling edge
   initial begin
      bit aw_fire, w_fire, ar_fire, b_fire, r_fire, p_aw, p_awf, p_w, p_wf, p_ar, p_arf, r_busy;
      logic [AW-1:0] p_awaddr, p_araddr, a, r_addr;
      logic [31:0] p_wdata, d;
      int aw_acc, w_acc, r_left;
      {aw_fire, w_fire, ar_fire, b_fire, r_fire, p_aw, p_awf, p_w, p_wf, p_ar, p_arf, r_busy} = '0;
      {p_awaddr, p_araddr, r_addr, p_wdata} = '0;
      {aw_acc, w_acc, r_left} = '0;
      {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid} = '0;
      {axi.bresp, axi.rresp, axi.rdata} = '0;
      forever begin
         @(negedge axi_clk);
         if (axi_reset) begin
            {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid} = '0;
            {b_fire, r_fire, p_aw, p_awf, p_w, p_wf, p_ar, p_arf, r_busy} = '0;
            awq.delete(); wq.delete(); bq.delete();
            aw_acc = 0; w_acc = 0;
         end else begin
            if (p_aw && !p_awf) begin
               chk("aw_hold", axi.awvalid, 1'b1);
               chk("awaddr_stable", axi.awaddr, p_awaddr);
            end
            if (p_w && !p_wf) begin
               chk("w_hold", axi.wvalid, 1'b1);
               chk("wdata_stable", axi.wdata, p_wdata);
            end
            if (p_ar && !p_arf) begin
               chk("ar_hold", axi.arvalid, 1'b1);
               chk("araddr_stable", axi.araddr, p_araddr);
            end
            chk("cmd_ready_while_busy", cmd_ready & busy, 1'b0);
            if (b_fire) axi.bvalid = 1'b0;
            if (r_fire) axi.rvalid = 1'b0;
            if (!axi.bvalid && bq.size() > 0 && !b_block && coin()) begin
               axi.bvalid = 1'b1;
               axi.bresp = bq.pop_front();
            end
            b_fire = axi.bvalid && axi.bready;
            if (r_busy && !axi.rvalid) begin
               if (r_left > 0) r_left--;
               if (r_left == 0) begin
                  axi.rvalid = 1'b1;
                  axi.rdata = smem[r_addr[9:2]];
                  axi.rresp = r_addr[8] ? 2'b10 : 2'b00;
                  r_busy = 1'b0;
               end
            end
            r_fire = axi.rvalid && axi.rready;
            axi.awready = coin();
            aw_fire = axi.awvalid && axi.awready;
            axi.wready = (!aw_first || aw_acc > w_acc) && coin();
            w_fire = axi.wvalid && axi.wready;
            if (axi.wvalid && !axi.wready) w_stall_cnt++;
            if (aw_fire) begin
               chk("awaddr_lsb", {30'd0, axi.awaddr[1:0]}, 32'd0);
               awq.push_back(axi.awaddr);
               last_awaddr = axi.awaddr;
               aw_acc++;
            end
            if (w_fire) begin
               chk("wstrb", {28'd0, axi.wstrb}, 32'hF);
               wq.push_back(axi.wdata);
               last_wdata = axi.wdata;
               last_wstrb = axi.wstrb;
               w_acc++;
            end
            while (awq.size() > 0 && wq.size() > 0) begin
               a = awq.pop_front();
               d = wq.pop_front();
               if (!a[8]) smem[a[9:2]] = d;
               bq.push_back(a[8] ? 2'b10 : 2'b00);
            end
            axi.arready = coin();
            ar_fire = axi.arvalid && axi.arready;
            if (ar_fire) begin
               chk("araddr_lsb", {30'd0, axi.araddr[1:0]}, 32'd0);
               r_busy = 1'b1;
               r_addr = axi.araddr;
               r_left = rd_lat >= 0 ? rd_lat : int'($urandom_range(0, 4));
            end
            if (axi.rready) rready_cnt++;
            if (axi.bready) bready_cnt++;
            p_aw = axi.awvalid; p_awf = aw_fire; p_awaddr = axi.awaddr;
            p_w = axi.wvalid; p_wf = w_fire; p_wdata = axi.wdata;
            p_ar = axi.arvalid; p_arf = ar_fire; p_araddr = axi.araddr;
         end
      end
   end

   task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
      int n = 0;
      while (!cmd_ready && n < 100) begin @(negedge axi_clk); n++; end
      chk("cmd_ready_wait", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      @(negedge axi_clk);
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [31:0] d, output logic [1:0] r);
      int n = 0;
      while (!rsp_valid && n < 500) begin @(negedge axi_clk); n++; end
      chk("rsp_wait", rsp_valid, 1'b1);
      d = rsp_rdata;
      r = rsp_resp;
      if (rnd_mode) repeat ($urandom_range(0, 2)) @(negedge axi_clk);
      rsp_ready = 1'b1;
      @(negedge axi_clk);
      rsp_ready = 1'b0;
      chk("rsp_once", rsp_valid, 1'b0);
   endtask

   initial begin
      logic [31:0] rd, exp_d, wd;
      logic [1:0] rs, exp_r;
      logic [AW-1:0] ad;
      logic w;
      int n;
      axi_reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 256; i++) begin smem[i] = $urandom; ref_mem[i] = smem[i]; end
      repeat (3) @(negedge axi_clk);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
      chk("rst_readies", {axi.bready, axi.rready}, 2'b00);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_resp", rsp_resp, 2'b00);
      chk("rst_awaddr", axi.awaddr, 0);
      chk("rst_wdata", axi.wdata, 32'd0);
      axi_reset = 1'b0;
      @(negedge axi_clk);

      // write with a slave that takes W only after AW
      aw_first = 1; w_stall_cnt = 0;
      send_cmd(1'b1, 18'h10, 32'hA5A5_1234);
      get_rsp(rd, rs);
      ref_mem[4] = 32'hA5A5_1234;
      chk("t1_awaddr", last_awaddr, 18'h10);
      chk("t1_wdata", last_wdata, 32'hA5A5_1234);
      chk("t1_wstrb", last_wstrb, 4'hF);
      chk("t1_w_stall", w_stall_cnt, 1);
      chk("t1_resp", rs, 2'b00);
      chk("t1_rdata", rd, 32'd0);
      chk("t1_mem", smem[4], 32'hA5A5_1234);
      aw_first = 0;

      // read with three cycles of slave latency
      smem[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;
      rd_lat = 3; rready_cnt = 0;
      send_cmd(1'b0, 18'h4, 32'd0);
      get_rsp(rd, rs);
      chk("t2_rdata", rd, 32'h1122_3344);
      chk("t2_resp", rs, 2'b00);
      chk("t2_rready_cycles", rready_cnt, 3);
      chk("t2_rready_low", axi.rready, 1'b0);

      // response held back for ten cycles while a new command waits
      rd_lat = 1;
      send_cmd(1'b0, 18'h8, 32'd0);
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge axi_clk); n++; end
      exp_d = ref_mem[2];
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 18'h30; cmd_wdata = 32'h0BAD_F00D;
      for (int k = 0; k < 10; k++) begin
         chk("hold_rsp_valid", rsp_valid, 1'b1);
         chk("hold_rsp_rdata", rsp_rdata, exp_d);
         chk("hold_cmd_ready", cmd_ready, 1'b0);
         chk("hold_axi_idle", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
         @(negedge axi_clk);
      end
      rsp_ready = 1'b1;
      @(negedge axi_clk);
      rsp_ready = 1'b0;
      chk("b2b_not_taken", busy, 1'b0);
      chk("b2b_cmd_ready", cmd_ready, 1'b1);
      @(negedge axi_clk);
      cmd_valid = 1'b0;
      chk("b2b_taken", busy, 1'b1);
      get_rsp(rd, rs);
      ref_mem[12] = 32'h0BAD_F00D;
      chk("b2b_resp", rs, 2'b00);

      // randomized mixed traffic with backpressure on every channel
      rnd_mode = 1; rd_lat = -1;
      repeat (1000) begin
         w = 1'(($urandom_range(0, 1)));
         ad = AW'($urandom_range(0, 1023));
         wd = $urandom;
         aw_first = 1'($urandom_range(0, 1));
         exp_r = ad[8] ? 2'b10 : 2'b00;
         exp_d = w ? 32'd0 : ref_mem[ad[9:2]];
         if (w && !ad[8]) ref_mem[ad[9:2]] = wd;
         send_cmd(w, ad, wd);
         get_rsp(rd, rs);
         chk(w ? "rnd_wr_rdata" : "rnd_rd_rdata", rd, exp_d);
         chk(w ? "rnd_wr_resp" : "rnd_rd_resp", rs, exp_r);
      end
      rnd_mode = 0; aw_first = 0; rd_lat = 0;
      repeat (2) @(negedge axi_clk);

`ifdef HSCI_AXIM_TIMEOUT_EN
      // slave never returns a write response
      b_block = 1; bready_cnt = 0;
      send_cmd(1'b1, 18'h20, 32'hCAFE_0001);
      get_rsp(rd, rs);
      ref_mem[8] = 32'hCAFE_0001;
      chk("to_resp", rs, 2'b11);
      chk("to_rdata", rd, 32'hDEAD_BEEF);
      chk("to_cycles", bready_cnt, 16);
      bq.delete(); b_block = 0;
      send_cmd(1'b0, 18'h20, 32'd0);
      get_rsp(rd, rs);
      chk("to_next_rdata", rd, 32'hCAFE_0001);
      chk("to_next_resp", rs, 2'b00);
`endif

      // reset while waiting for read data
      rd_lat = 10;
      send_cmd(1'b0, 18'h40, 32'd0);
      n = 0;
      while (!axi.rready && n < 20) begin @(negedge axi_clk); n++; end
      chk("rst_mid_in_rd_data", axi.rready, 1'b1);
      axi_reset = 1'b1;
      @(negedge axi_clk);
      chk("rst_mid_arvalid", axi.arvalid, 1'b0);
      chk("rst_mid_rready", axi.rready, 1'b0);
      chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      axi_reset = 1'b0;
      @(negedge axi_clk);
      chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
      chk("rst_mid_rdata", rsp_rdata, 32'd0);
      rd_lat = 2;
      send_cmd(1'b0, 18'h40, 32'd0);
      get_rsp(rd, rs);
      chk("post_rst_rdata", rd, ref_mem[16]);
      chk("post_rst_resp", rs, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
